alu_cmd_sequencer: RTL
======================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: command FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter TAG_W, default 4: width of the command/response tag.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid, input, 1: command offered.
REQ-006 SHALL have port cmd_ready, output, 1: command FIFO can accept.
REQ-007 SHALL have ports cmd_a, input, 32; cmd_b, input, 32; cmd_sel, input, 3; cmd_tag, input, TAG_W: command fields.
REQ-008 SHALL have ports alu_a, output, 32; alu_b, output, 32; alu_sel, output, 3: operands and opcode driven to the external combinational ALU.
REQ-009 SHALL have port alu_result, input, 32: combinational ALU output.
REQ-010 SHALL have port rsp_valid, output, 1, and rsp_ready, input, 1: response handshake.
REQ-011 SHALL have ports rsp_data, output, 32, and rsp_tag, output, TAG_W: result and tag of the completed command.
REQ-012 SHALL have port busy, output, 1: high when FIFO non-empty or FSM not in IDLE.

Function
REQ-013 SHALL accept a command on a rising edge where cmd_valid && cmd_ready; cmd_ready = !fifo_full, independent of a same-cycle pop.
REQ-014 SHALL pass commands to the ALU in strict FIFO order; no reordering, no drop, no duplication.
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 IDLE: if FIFO non-empty, pop head into operand/opcode/tag registers and go to EXEC; else stay.
REQ-017 EXEC (exactly one cycle): alu_a/alu_b/alu_sel driven from the registers; at the edge, capture alu_result into rsp_data, load rsp_tag, set rsp_valid, go to RESP.
REQ-018 RESP: hold rsp_valid, rsp_data, rsp_tag stable until rsp_valid && rsp_ready; at that edge, if FIFO non-empty, pop next and go to EXEC, else clear rsp_valid and go to IDLE.
REQ-019 alu_a/alu_b/alu_sel SHALL hold the last issued values outside EXEC.
REQ-020 Latency: command accepted into an empty FIFO with FSM in IDLE at edge k -> rsp_valid high after edge k+2.
REQ-021 Throughput: with rsp_ready held high, one response per 2 cycles.
REQ-022 Simultaneous push and pop in one cycle SHALL leave the FIFO count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-023 A push into an empty FIFO SHALL NOT be popped in the same cycle; it is visible next cycle.
REQ-024 The result SHALL be passed through unmodified for all eight opcodes, including division by zero (ALU returns 0).

Reset
REQ-025 rst_n low SHALL immediately force: FSM IDLE, FIFO empty, cmd_ready 1 (after release), rsp_valid 0, rsp_data 0, rsp_tag 0, alu_a 0, alu_b 0, alu_sel 3'b000, busy 0.
REQ-026 Reset mid-operation SHALL discard queued and in-flight commands; no response is produced for them after release.
REQ-027 First command SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro ALU_DIVZERO_FLAG_EN defined: output port rsp_err, 1 bit, SHALL be set with the response when alu_sel == 3'b111 and alu_b == 0 in EXEC, cleared otherwise, reset to 0, held stable in RESP.
REQ-029 ALU_DIVZERO_FLAG_EN undefined: rsp_err port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Single ADD: reset, push A=0x0000_0005, B=0x0000_0003, sel=100, tag=1, rsp_ready=1 -> rsp_valid 2 cycles after acceptance, rsp_data=0x0000_0008, rsp_tag=1.
REQ-031 Backpressure: rsp_ready=0, push 5 commands (depth 4) -> cmd_ready low after 4th FIFO entry plus 1 in RESP; release rsp_ready -> 5 responses in push order, data stable while stalled.
REQ-032 Full opcode sweep: A=0x0000_000C, B=0x0000_0004, sel 000..111 -> 0xFFFF_FFF3, 0x4, 0xC, 0xFFFF_FFF4, 0x10, 0x8, 0x30, 0x3.
REQ-033 Divide by zero: A=0x10, B=0, sel=111 -> rsp_data=0; with ALU_DIVZERO_FLAG_EN rsp_err=1, next command sel=100 -> rsp_err=0.
REQ-034 Simultaneous push/pop with FIFO holding 2 entries and rsp handshake completing -> count stays 2, order preserved across pointer wrap (push 10 commands tags 0..9).
REQ-035 Reset mid-operation: assert rst_n low while in EXEC with 3 queued -> rsp_valid 0, busy 0, no responses after release; new command then completes normally.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands in a FIFO and issues them one at a
// time to an external combinational ALU. Each result is returned with the
// command's tag over a valid/ready response handshake.
//
// Parameters: FIFO_DEPTH (power of two, 2..16), TAG_W.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_a, cmd_b, cmd_sel, cmd_tag    command fields
//   alu_a, alu_b, alu_sel             operands/opcode to the external ALU
//   alu_result                        combinational ALU result
//   rsp_valid/rsp_ready               response handshake
//   rsp_data, rsp_tag                 result and tag of the completed command
//   rsp_err                           divide-by-zero flag (only with ALU_DIVZERO_FLAG_EN)
//   busy                              FIFO non-empty or command in flight
// Optional feature macro: ALU_DIVZERO_FLAG_EN adds the rsp_err port.
module alu_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [2:0]       cmd_sel,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_sel,
    input  logic [31:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
`ifdef ALU_DIVZERO_FLAG_EN
    output logic             rsp_err,
`endif
    output logic             busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [2:0]       sel;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    cmd_t             mem [FIFO_DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TAG_W-1:0] op_tag;
    logic             push, pop;

    // cmd_ready is a registered !full, so a same-cycle pop never frees space early
    assign push = cmd_valid && cmd_ready;
    assign head = mem[rd_ptr];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pop decision; pop only looks at the registered count,
    // so an entry pushed into an empty FIFO is not visible until next cycle
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Occupancy update; push and pop together leave it unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage (no reset needed: validity is tracked by count_q)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, sel: cmd_sel, tag: cmd_tag};
        end
    end

    // FIFO pointers, occupancy and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_q   <= count_d;
            cmd_ready <= (count_d != FULL_CNT);
            busy      <= (count_d != '0) || (state_d != IDLE);
        end
    end

    // Operand registers double as ALU drive (hold last issued values);
    // the response is captured at the end of the single EXEC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= 3'b000;
            op_tag    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
        end else begin
            if (pop) begin
                alu_a   <= head.a;
                alu_b   <= head.b;
                alu_sel <= head.sel;
                op_tag  <= head.tag;
            end
            if (state_q == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_data  <= alu_result;
                rsp_tag   <= op_tag;
            end else if (state_q == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_DIVZERO_FLAG_EN
    // Divide-by-zero flag travels with the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_err <= (alu_sel == 3'b111) && (alu_b == 32'd0);
        end
    end
`endif

endmodule
